alu_instr_issuer: RTL and testbench
===================================

ALU_INSTR_ISSUER -- requirements
Module: alu_instr_issuer

Interface
REQ-001 Parameter ALU_LATENCY, default 1: number of clk rising edges between driving an instruction and the ALU result being valid; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  issuer can accept a request.
REQ-006 req_op  input  2  opcode: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-007 req_a  input  8  operand A.
REQ-008 req_b  input  8  operand B.
REQ-009 instruction  output  18  to ALU; [17:16] opcode, [15:8] A, [7:0] B.
REQ-010 alu_out  input  8  ALU low result byte.
REQ-011 alu_extended_out  input  8  ALU high result byte.
REQ-012 alu_overflow  input  1  ALU overflow flag.
REQ-013 alu_carry  input  1  ALU carry flag.
REQ-014 resp_valid  output  1  response present.
REQ-015 resp_ready  input  1  consumer accepts response.
REQ-016 resp_result  output  16  {alu_extended_out, alu_out} as captured.
REQ-017 resp_overflow, resp_carry  output  1 each  captured flags.
REQ-018 resp_op  output  2  opcode of the response's request.
REQ-019 issued_count  output  8  number of completed transactions, wraps.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; one-hot or binary encoding is free.
REQ-021 IDLE: req_ready=1; on req_valid&&req_ready, register {req_op,req_a,req_b} onto instruction, load wait counter with ALU_LATENCY, go to ISSUE.
REQ-022 ISSUE: one cycle, req_ready=0, instruction held; go to WAIT.
REQ-023 WAIT: counter decrements each cycle; when counter reaches 1 and decrements, capture alu_out, alu_extended_out, alu_overflow, alu_carry and the current opcode into response registers, assert resp_valid, go to RESP.
REQ-024 Accept-to-resp_valid latency is exactly ALU_LATENCY+1 cycles.
REQ-025 RESP: resp_valid=1 and all resp_* outputs stable until resp_valid&&resp_ready; on that edge resp_valid=0, issued_count increments, state returns to IDLE.
REQ-026 req_ready is 1 only in IDLE; requests offered in any other state are ignored and not lost by the issuer (requester holds them per valid/ready rule).
REQ-027 instruction holds the last issued value in all states until the next accept.
REQ-028 ALU inputs are sampled only on the capture edge; changes at other times have no effect.
REQ-029 issued_count wraps 255 -> 0 with no flag.
REQ-030 resp_ready held high in RESP with req_valid high: next request accepted no earlier than the cycle after the handshake (one IDLE cycle minimum between transactions).
REQ-031 Divide by zero is not checked; whatever the ALU presents is captured.

Reset
REQ-032 rst_n low, at any time including mid-transaction: state=IDLE, instruction=0, resp_valid=0, resp_result=0, resp_overflow=0, resp_carry=0, resp_op=0, issued_count=0, wait counter=0; req_ready=1 from the first edge after release.
REQ-033 An in-flight transaction aborted by reset produces no response and no count increment.

Structure
REQ-034 Shared package holds opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), instruction field positions and width (18), and FSM state encoding.
REQ-035 Single flat module; no sub-module; intended to instantiate directly in front of alu8bit.

Verification
REQ-036 Add: op=00, A=0x01, B=0x01, ALU_LATENCY=1 -> instruction=18'b000000000100000001 one cycle after accept; resp_valid exactly 2 cycles after accept; resp_result=0x0002, flags 0.
REQ-037 Multiply: op=10, A=0x10, B=0x10 -> resp_result=0x0100, resp_op=10.
REQ-038 Backpressure: resp_ready low for 10 cycles in RESP -> resp_* stable, req_ready=0, second req_valid ignored; released -> issued_count +1, second request then accepted.
REQ-039 Reset mid-WAIT with ALU_LATENCY=15 -> all outputs return to REQ-032 values, no resp_valid, issued_count unchanged at 0.
REQ-040 Wrap: 256 back-to-back add transactions -> issued_count reads 0 after the 256th handshake; ALU inputs toggled outside capture edge never appear in resp_result.

Source files
------------

// File: rtl/alu_instr_issuer_pkg.sv
// Shared definitions for the ALU instruction issuer: opcodes, instruction layout, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_instr_issuer_pkg;

  // Opcode values as seen on req_op / instruction[17:16] / resp_op.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Instruction word layout: {opcode, A, B}.
  localparam int INSTR_W = 18;
  localparam int OP_MSB  = 17;
  localparam int OP_LSB  = 16;
  localparam int A_MSB   = 15;
  localparam int A_LSB   = 8;
  localparam int B_MSB   = 7;
  localparam int B_LSB   = 0;

  // Wait counter must hold the largest legal ALU latency (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [INSTR_W-1:0] pack_instr(input logic [1:0] op,
                                                    input logic [7:0] a,
                                                    input logic [7:0] b);
    return {op, a, b};
  endfunction

endpackage

// File: rtl/alu_instr_issuer.sv
// Issues one instruction at a time to a fixed-latency 8-bit ALU and returns its captured result.
// Latency: resp_valid rises exactly ALU_LATENCY+1 cycles after the request handshake.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready, then one IDLE cycle.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready, req_op/a/b    request handshake and fields
//   instruction[17:0]                  {op, A, B} driven to the ALU, held until next accept
//   alu_out, alu_extended_out,
//   alu_overflow, alu_carry            ALU results, sampled only on the capture edge
//   resp_valid/resp_ready, resp_*      response handshake and captured result/flags/opcode
//   issued_count[7:0]                  completed transactions, wraps silently
module alu_instr_issuer
  import alu_instr_issuer_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [7:0]         req_a,
  input  logic [7:0]         req_b,
  output logic [INSTR_W-1:0] instruction,
  input  logic [7:0]         alu_out,
  input  logic [7:0]         alu_extended_out,
  input  logic               alu_overflow,
  input  logic               alu_carry,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [15:0]        resp_result,
  output logic               resp_overflow,
  output logic               resp_carry,
  output logic [1:0]         resp_op,
  output logic [7:0]         issued_count
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(ALU_LATENCY);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 carry_q, carry_d;
  logic [1:0]           op_q, op_d;
  logic [7:0]           count_q, count_d;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    carry_d   = carry_q;
    op_d      = op_q;
    count_d   = count_q;
    req_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          instr_d = pack_instr(req_op, req_a, req_b);
          cnt_d   = LAT_CNT;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A zero count can only arise from an illegal latency; treat it like
        // the last count so the FSM can never stall in WAIT.
        if (cnt_q <= 4'd1) begin
          cnt_d    = '0;
          result_d = {alu_extended_out, alu_out};
          ovf_d    = alu_overflow;
          carry_d  = alu_carry;
          op_d     = instr_q[OP_MSB:OP_LSB];
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          count_d = count_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      count_q  <= count_d;
    end
  end

  assign instruction   = instr_q;
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_result   = result_q;
  assign resp_overflow = ovf_q;
  assign resp_carry    = carry_q;
  assign resp_op       = op_q;
  assign issued_count  = count_q;

endmodule

// File: tb/tb_alu_instr_issuer.sv
// Scoreboard bench for alu_instr_issuer: randomized requests against a behavioural ALU/issuer model.
// Latency: checks resp_valid at exactly ALU_LATENCY+1 cycles after accept.
// Backpressure: exercises held resp_ready low, random resp_ready, back-to-back requests.
module tb_alu_instr_issuer;
  import alu_instr_issuer_pkg::*;

  localparam int L  = 1;
  localparam int L2 = 15;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] res;
    logic        ovf;
    logic        cy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (latency 1)
  logic        rst_n, req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0]  req_op, resp_op;
  logic [7:0]  req_a, req_b, alu_out, alu_ext, issued_count;
  logic        alu_ovf, alu_cy, resp_overflow, resp_carry;
  logic [17:0] instruction;
  logic [15:0] resp_result;

  // Second DUT (latency 15) for reset-abort and long-latency checks
  logic        l_rst_n, l_req_valid, l_req_ready, l_resp_valid, l_resp_ready;
  logic [1:0]  l_req_op, l_resp_op;
  logic [7:0]  l_req_a, l_req_b, l_issued_count;
  logic        l_resp_overflow, l_resp_carry;
  logic [17:0] l_instruction;
  logic [15:0] l_resp_result;

  alu_instr_issuer #(.ALU_LATENCY(L)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .instruction(instruction),
    .alu_out(alu_out), .alu_extended_out(alu_ext),
    .alu_overflow(alu_ovf), .alu_carry(alu_cy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_overflow(resp_overflow),
    .resp_carry(resp_carry), .resp_op(resp_op),
    .issued_count(issued_count)
  );

  alu_instr_issuer #(.ALU_LATENCY(L2)) u_dut15 (
    .clk(clk), .rst_n(l_rst_n),
    .req_valid(l_req_valid), .req_ready(l_req_ready),
    .req_op(l_req_op), .req_a(l_req_a), .req_b(l_req_b),
    .instruction(l_instruction),
    .alu_out(8'hA5), .alu_extended_out(8'h5A),
    .alu_overflow(1'b1), .alu_carry(1'b0),
    .resp_valid(l_resp_valid), .resp_ready(l_resp_ready),
    .resp_result(l_resp_result), .resp_overflow(l_resp_overflow),
    .resp_carry(l_resp_carry), .resp_op(l_resp_op),
    .issued_count(l_issued_count)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  logic [7:0] exp_cnt = 8'd0;
  int   hs_total = 0;
  int   rr_mode = 1;   // 0: resp_ready low, 1: high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: what a well-behaved 8-bit ALU would present for each opcode.
  function automatic exp_t alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0] s;
    e.op = op; e.res = '0; e.ovf = 1'b0; e.cy = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = {7'd0, s}; e.cy = s[8];
        e.ovf = (a[7] == b[7]) && (s[7] != a[7]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        e.res = {{7{s[8]}}, s}; e.cy = s[8];
        e.ovf = (a[7] != b[7]) && (s[7] != a[7]);
      end
      OP_MUL: begin
        e.res = 16'(a) * 16'(b);
        e.ovf = (e.res[15:8] != 8'd0);
      end
      default: begin
        if (b == 8'd0) begin e.res = 16'hFFFF; e.ovf = 1'b1; end
        else e.res = {a % b, a / b};
      end
    endcase
    return e;
  endfunction

  // ALU stand-in: presents the correct result only just before the capture edge
  // (accept edge + L + 1) and random garbage on every other cycle.
  initial begin : alu_drv
    logic pend;
    int   cnt;
    exp_t e;
    logic [17:0] iw;
    pend = 1'b0; cnt = 0; e = '0; iw = '0;
    alu_out = '0; alu_ext = '0; alu_ovf = 1'b0; alu_cy = 1'b0;
    forever begin
      @(negedge clk);
      alu_out = 8'($urandom); alu_ext = 8'($urandom);
      alu_ovf = 1'($urandom); alu_cy = 1'($urandom);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        cnt++;
        if (cnt == 1) begin
          check("instruction", 32'(instruction), 32'(iw));
          check("req_ready_busy", 32'(req_ready), 32'd0);
        end
        if (cnt == L + 1) begin
          alu_out = e.res[7:0]; alu_ext = e.res[15:8];
          alu_ovf = e.ovf;      alu_cy  = e.cy;
          check("resp_valid_early", 32'(resp_valid), 32'd0);
        end
        if (cnt == L + 2) begin
          check("resp_valid_latency", 32'(resp_valid), 32'd1);
          pend = 1'b0;
        end
      end
      if (rst_n && !pend && req_valid && req_ready) begin
        pend = 1'b1; cnt = 0;
        iw = {req_op, req_a, req_b};
        e  = alu_ref(req_op, req_a, req_b);
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: compares every presented response with the scoreboard head.
  initial begin : monitor
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt = 8'd0;
        sb_q.delete();
      end else begin
        check("issued_count", 32'(issued_count), 32'(exp_cnt));
        if (resp_valid) begin
          if (sb_q.size() == 0) begin
            check("spurious_resp", 32'(resp_valid), 32'd0);
          end else begin
            h = sb_q[0];
            check("resp", 32'({resp_op, resp_result, resp_overflow, resp_carry}), 32'(h));
            if (resp_ready) begin
              void'(sb_q.pop_front());
              exp_cnt = exp_cnt + 8'd1;
              hs_total++;
            end
          end
        end
      end
    end
  end

  initial begin : rr_drv
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rr_mode)
        0:       resp_ready = 1'b0;
        1:       resp_ready = 1'b1;
        default: resp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge with req_valid still high.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    do begin @(negedge clk); t++; end while (!req_ready && t < 200);
    check("send_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    while (!resp_valid && t < 100) begin @(negedge clk); t++; end
    check("resp_seen", 32'(resp_valid), 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    check("drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_main();
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp", 32'({resp_op, resp_result, resp_overflow, resp_carry}), 32'd0);
    check("rst_count", 32'(issued_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin : main
    int gap, hs0, t, lat;
    logic seen;
    rst_n = 1'b0; l_rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    l_req_valid = 1'b0; l_req_op = '0; l_req_a = '0; l_req_b = '0; l_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_main();
    rst_n = 1'b1; l_rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed add 1+1
    send(OP_ADD, 8'h01, 8'h01);
    req_valid = 1'b0;
    check("add_instruction", 32'(instruction), 32'(18'b000000000100000001));
    wait_resp();
    check("add_result", 32'(resp_result), 32'h0002);
    check("add_flags", 32'({resp_overflow, resp_carry}), 32'd0);
    @(posedge clk); #1;

    // Directed multiply
    send(OP_MUL, 8'h10, 8'h10);
    req_valid = 1'b0;
    wait_resp();
    check("mul_result", 32'(resp_result), 32'h0100);
    check("mul_op", 32'(resp_op), 32'(2'b10));
    @(posedge clk); #1;

    // Backpressure: response held, second request offered and ignored
    rr_mode = 0;
    send(OP_SUB, 8'($urandom), 8'($urandom));
    req_op = OP_DIV; req_a = 8'h64; req_b = 8'h00;
    wait_resp();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
    end
    @(posedge clk); #1;
    hs0 = hs_total;
    rr_mode = 1;
    send(OP_DIV, 8'h64, 8'h00);
    req_valid = 1'b0;
    check("bp_released", 32'(hs_total - hs0), 32'd1);
    wait_resp();
    @(posedge clk); #1;

    // Random traffic with random response backpressure
    rr_mode = 2;
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        req_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      send(2'($urandom), 8'($urandom), 8'($urandom));
    end
    req_valid = 1'b0;
    rr_mode = 1;
    drain();

    // Wrap: reset, then 256 back-to-back adds
    rst_n = 1'b0;
    #1;
    check_reset_main();
    @(posedge clk); #1;
    rst_n = 1'b1;
    hs0 = hs_total;
    for (int n = 0; n < 256; n++) send(OP_ADD, 8'($urandom), 8'($urandom));
    req_valid = 1'b0;
    drain();
    check("wrap_handshakes", 32'(hs_total - hs0), 32'd256);
    check("wrap_count", 32'(issued_count), 32'd0);

    // Latency-15 instance: reset in the middle of WAIT aborts the transaction
    l_req_valid = 1'b1; l_req_op = OP_DIV; l_req_a = 8'h20; l_req_b = 8'h04;
    @(negedge clk);
    check("l_req_ready", 32'(l_req_ready), 32'd1);
    @(posedge clk); #1;
    l_req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    l_rst_n = 1'b0;
    #1;
    check("l_rst_instruction", 32'(l_instruction), 32'd0);
    check("l_rst_resp", 32'({l_resp_valid, l_resp_op, l_resp_result, l_resp_overflow, l_resp_carry}), 32'd0);
    check("l_rst_count", 32'(l_issued_count), 32'd0);
    check("l_rst_req_ready", 32'(l_req_ready), 32'd1);
    @(posedge clk); #1;
    l_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (l_resp_valid) seen = 1'b1;
    end
    check("l_no_resp_after_abort", 32'(seen), 32'd0);
    check("l_count_after_abort", 32'(l_issued_count), 32'd0);
    @(posedge clk); #1;

    // Latency-15 full transaction
    l_req_valid = 1'b1; l_req_op = OP_DIV; l_req_a = 8'h20; l_req_b = 8'h04;
    @(posedge clk); #1;
    l_req_valid = 1'b0;
    t = 0; lat = 0;
    while (!l_resp_valid && t < 100) begin @(negedge clk); t++; end
    lat = t;
    // Counted from just after the accept edge: L2+1 edges plus the half cycle to the negedge.
    check("l_latency", 32'(lat), 32'(L2 + 2));
    check("l_result", 32'({l_resp_op, l_resp_result, l_resp_overflow, l_resp_carry}),
          32'({OP_DIV, 16'h5AA5, 1'b1, 1'b0}));
    l_resp_ready = 1'b1;
    @(posedge clk); #1;
    l_resp_ready = 1'b0;
    check("l_count_done", 32'(l_issued_count), 32'd1);
    check("l_idle_after", 32'({l_resp_valid, l_req_ready}), 32'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
